flight_cmd_sequencer: RTL and testbench
=======================================

Name: flight_cmd_sequencer

Overview:
- Command dispatcher between the UART command wrapper and the flight controller.
- Accepts decoded host commands (cmd/data pairs) and updates the desired pitch/roll/yaw/thrust registers.
- Sequences the ESC spin-up and inertial calibration handshake, and returns a one-byte response for every command.
- Contains a link-loss watchdog that forces an emergency landing when the host goes silent while the motors are enabled.

Parameters:
- SPIN_W, 20, width of ESC spin-up counter; spin-up lasts 2^SPIN_W clk cycles (benches use 6).
- LOSS_W, 26, width of link-loss watchdog counter; expiry at 2^LOSS_W-1 idle cycles (benches use 8).
- ACK, 8'hA5, response byte for an accepted command.
- NAK, 8'hEE, response byte for an unknown opcode.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_rdy  in  1  command/data valid; held high by the wrapper until clr_cmd_rdy
- cmd  in  8  opcode
- data  in  16  operand
- cal_done  in  1  one-cycle pulse from the inertial integrator, calibration complete
- clr_cmd_rdy  out  1  one-cycle pulse, consumes the current command
- send_resp  out  1  one-cycle pulse, transmit resp
- resp  out  8  response byte
- d_ptch  out  16  desired pitch, signed
- d_roll  out  16  desired roll, signed
- d_yaw  out  16  desired yaw, signed
- thrst  out  9  desired thrust, unsigned
- strt_cal  out  1  one-cycle pulse, start inertial calibration
- inertial_cal  out  1  high from spin-up start until cal_done
- motors_off  out  1  forces ESC outputs off
- link_lost  out  1  sticky flag, watchdog fired

Behaviour:
- Opcodes:
  - 02 SET_PTCH: d_ptch<=data.
  - 03 SET_ROLL: d_roll<=data.
  - 04 SET_YAW: d_yaw<=data.
  - 05 SET_THRST: thrst<=data[8:0]; data[15:9] ignored.
  - 06 SET_CAL: calibration sequence.
  - 07 SET_EMGL: d_ptch, d_roll, d_yaw, thrst <=0; motors stay enabled.
  - 08 SET_MOFF: thrst<=0, motors_off<=1.
  - Any other opcode: no register change, resp=NAK.
- Reset values: d_ptch, d_roll, d_yaw = 0; thrst = 0; motors_off = 1; inertial_cal = 0; link_lost = 0; all pulses = 0; resp = 8'h00; state = IDLE; counters = 0.
- FSM states: IDLE, SPIN, CAL, RESP.
  - IDLE, cmd_rdy=1:
    - Assert clr_cmd_rdy that cycle.
    - Opcodes 02-05, 07, 08, unknown: apply the register update on the same edge and go to RESP with resp=ACK or NAK.
    - 06: motors_off<=0, inertial_cal<=1, clear spin counter, go to SPIN.
  - SPIN: count; on counter all-ones, pulse strt_cal for one cycle and go to CAL.
  - CAL: wait for cal_done; then inertial_cal<=0, resp<=ACK, go to RESP.
  - RESP: pulse send_resp for one cycle with resp stable; return to IDLE next cycle.
- Latency:
  - Simple commands: cmd_rdy high at cycle N gives register update and clr_cmd_rdy at edge N, send_resp at N+1.
  - SET_CAL: send_resp one cycle after the cal_done cycle.
- Commands are not accepted outside IDLE. cmd_rdy stays pending and is serviced on return to IDLE; no command is ever dropped or double-consumed.
- SET_CAL received while already flying (motors_off=0) reruns the full sequence. Setpoints are not changed.
- cal_done arriving outside CAL is ignored.
- Watchdog:
  - Counter clears on every accepted command and whenever motors_off=1; otherwise it increments each cycle.
  - At 2^LOSS_W-1: zero d_ptch, d_roll, d_yaw and thrst, set link_lost, clear counter.
  - No response is sent and motors_off is unchanged.
  - link_lost clears only on an accepted SET_CAL or on rst.
  - If expiry and cmd_rdy coincide in IDLE, the command wins and the watchdog clears without firing.
  - The watchdog is frozen outside IDLE, so calibration time never trips it.
- rst mid-sequence (SPIN/CAL/RESP) returns everything to reset values next edge. No send_resp is emitted for the aborted command.
- Arithmetic: thrust truncated to 9 bits with no saturation; angles passed through unmodified.

Test Plan:
- Reset, then SET_PTCH data=16'h0100 -> clr_cmd_rdy same cycle; d_ptch=16'h0100; send_resp next cycle with resp=8'hA5; other setpoints still 0.
- SET_CAL (SPIN_W=6) -> inertial_cal=1 and motors_off=0 immediately; strt_cal pulses exactly 64 cycles later. Drive cal_done 10 cycles after that -> inertial_cal=0; send_resp with A5 one cycle later.
- SET_THRST data=16'hFEFF, then SET_ROLL data=16'hFF80 held pending during RESP -> thrst=9'h0FF; d_roll=16'hFF80; two send_resp pulses, each followed by exactly one clr_cmd_rdy.
- Opcode 8'h3C -> resp=8'hEE; no register changes. Then SET_EMGL -> all four setpoints 0, motors_off stays 0, resp=A5.
- LOSS_W=8, motors enabled with thrst=9'h0FF, no commands -> at 255 idle cycles thrst=0, angles 0, link_lost=1, no send_resp. Separately, cmd_rdy arriving on the expiry cycle -> command applied, link_lost stays 0.
- rst asserted during CAL -> next edge motors_off=1, inertial_cal=0, setpoints 0; a later cal_done produces no response. SET_MOFF during flight -> motors_off=1, thrst=0, A5.

Source files
------------

// File: rtl/flight_cmd_sequencer.sv
// Command dispatcher between the UART command wrapper and the flight controller:
// setpoint registers, ESC spin-up / calibration sequencing and link-loss watchdog.
module flight_cmd_sequencer #(
   parameter int         SPIN_W = 20,
   parameter int         LOSS_W = 26,
   parameter logic [7:0] ACK    = 8'hA5,
   parameter logic [7:0] NAK    = 8'hEE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_rdy,
   input  logic [7:0]  cmd,
   input  logic [15:0] data,
   input  logic        cal_done,
   output logic        clr_cmd_rdy,
   output logic        send_resp,
   output logic [7:0]  resp,
   output logic [15:0] d_ptch,
   output logic [15:0] d_roll,
   output logic [15:0] d_yaw,
   output logic [8:0]  thrst,
   output logic        strt_cal,
   output logic        inertial_cal,
   output logic        motors_off,
   output logic        link_lost
);

   localparam logic [7:0] OP_PTCH  = 8'h02;
   localparam logic [7:0] OP_ROLL  = 8'h03;
   localparam logic [7:0] OP_YAW   = 8'h04;
   localparam logic [7:0] OP_THRST = 8'h05;
   localparam logic [7:0] OP_CAL   = 8'h06;
   localparam logic [7:0] OP_EMGL  = 8'h07;
   localparam logic [7:0] OP_MOFF  = 8'h08;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SPIN = 2'd1,
      CAL  = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t            state_r;
   state_t            next_state_s;
   logic [SPIN_W-1:0] spin_cnt_r;
   logic [LOSS_W-1:0] wd_cnt_r;
   logic [LOSS_W-1:0] wd_inc_s;
   logic              accept_s;
   logic              spin_done_s;
   logic              wd_fire_s;

   assign accept_s    = (state_r == IDLE) && cmd_rdy;
   assign spin_done_s = &spin_cnt_r;
   assign wd_inc_s    = wd_cnt_r + {{(LOSS_W-1){1'b0}}, 1'b1};
   // A pending command always beats a watchdog expiry on the same cycle.
   assign wd_fire_s   = (state_r == IDLE) && !cmd_rdy && !motors_off && (&wd_inc_s);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (cmd_rdy) begin
               if (cmd == OP_CAL) begin
                  next_state_s = SPIN;
               end else begin
                  next_state_s = RESP;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         SPIN: begin
            if (spin_done_s) begin
               next_state_s = CAL;
            end else begin
               next_state_s = SPIN;
            end
         end
         CAL: begin
            if (cal_done) begin
               next_state_s = RESP;
            end else begin
               next_state_s = CAL;
            end
         end
         RESP:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Handshake pulse decode
   always_comb begin
      clr_cmd_rdy = accept_s;
      send_resp   = (state_r == RESP);
      strt_cal    = (state_r == SPIN) && spin_done_s;
   end

   // Setpoints, flags, response byte and spin-up counter
   always_ff @(posedge clk) begin
      if (rst) begin
         d_ptch       <= 16'h0000;
         d_roll       <= 16'h0000;
         d_yaw        <= 16'h0000;
         thrst        <= 9'h000;
         motors_off   <= 1'b1;
         inertial_cal <= 1'b0;
         link_lost    <= 1'b0;
         resp         <= 8'h00;
         spin_cnt_r   <= {SPIN_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (cmd_rdy) begin
                  resp <= ACK;
                  case (cmd)
                     OP_PTCH:  d_ptch <= data;
                     OP_ROLL:  d_roll <= data;
                     OP_YAW:   d_yaw  <= data;
                     OP_THRST: thrst  <= data[8:0];
                     OP_CAL: begin
                        motors_off   <= 1'b0;
                        inertial_cal <= 1'b1;
                        link_lost    <= 1'b0;
                        spin_cnt_r   <= {SPIN_W{1'b0}};
                     end
                     OP_EMGL: begin
                        d_ptch <= 16'h0000;
                        d_roll <= 16'h0000;
                        d_yaw  <= 16'h0000;
                        thrst  <= 9'h000;
                     end
                     OP_MOFF: begin
                        thrst      <= 9'h000;
                        motors_off <= 1'b1;
                     end
                     default: resp <= NAK;
                  endcase
               end else if (wd_fire_s) begin
                  d_ptch    <= 16'h0000;
                  d_roll    <= 16'h0000;
                  d_yaw     <= 16'h0000;
                  thrst     <= 9'h000;
                  link_lost <= 1'b1;
               end
            end
            SPIN: spin_cnt_r <= spin_cnt_r + {{(SPIN_W-1){1'b0}}, 1'b1};
            CAL: begin
               if (cal_done) begin
                  inertial_cal <= 1'b0;
                  resp         <= ACK;
               end
            end
            default: ;
         endcase
      end
   end

   // Link-loss watchdog counter; frozen outside IDLE so calibration never trips it
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_r <= {LOSS_W{1'b0}};
      end else if (accept_s || motors_off) begin
         wd_cnt_r <= {LOSS_W{1'b0}};
      end else if (state_r != IDLE) begin
         wd_cnt_r <= wd_cnt_r;
      end else if (&wd_inc_s) begin
         wd_cnt_r <= {LOSS_W{1'b0}};
      end else begin
         wd_cnt_r <= wd_inc_s;
      end
   end

endmodule

// File: tb/tb_flight_cmd_sequencer.sv
// Directed, table-driven bench for flight_cmd_sequencer (SPIN_W=6, LOSS_W=8).
module tb_flight_cmd_sequencer;

   logic        clk;
   logic        rst;
   logic        cmd_rdy;
   logic [7:0]  cmd;
   logic [15:0] data;
   logic        cal_done;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [7:0]  resp;
   logic [15:0] d_ptch;
   logic [15:0] d_roll;
   logic [15:0] d_yaw;
   logic [8:0]  thrst;
   logic        strt_cal;
   logic        inertial_cal;
   logic        motors_off;
   logic        link_lost;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0]  cmd;
      logic [15:0] data;
      logic [7:0]  rsp;
      logic [15:0] p;
      logic [15:0] r;
      logic [15:0] y;
      logic [8:0]  t;
      logic        m;
   } vec_t;

   vec_t vecs [14];

   // expected setpoint state carried between directed sequences
   logic [15:0] e_p, e_r, e_y;
   logic [8:0]  e_t;
   logic        e_m;

   flight_cmd_sequencer #(.SPIN_W(6), .LOSS_W(8)) dut (
      .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
      .cal_done(cal_done), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
      .resp(resp), .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
      .thrst(thrst), .strt_cal(strt_cal), .inertial_cal(inertial_cal),
      .motors_off(motors_off), .link_lost(link_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_setpoints(input string nm);
      check({nm, "_ptch"}, 32'(d_ptch), 32'(e_p));
      check({nm, "_roll"}, 32'(d_roll), 32'(e_r));
      check({nm, "_yaw"},  32'(d_yaw),  32'(e_y));
      check({nm, "_thr"},  32'(thrst),  32'(e_t));
      check({nm, "_moff"}, 32'(motors_off), 32'(e_m));
   endtask

   // one simple command: accept cycle, then RESP cycle; ends in first idle cycle
   task automatic do_vec(input int i);
      vec_t v;
      v = vecs[i];
      cmd_rdy = 1'b1;
      cmd     = v.cmd;
      data    = v.data;
      @(negedge clk);
      check($sformatf("v%0d_clr", i), 32'(clr_cmd_rdy), 32'd1);
      check($sformatf("v%0d_noresp", i), 32'(send_resp), 32'd0);
      tick();
      cmd_rdy = 1'b0;
      cmd     = 8'hFF;
      data    = 16'h0000;
      e_p = v.p; e_r = v.r; e_y = v.y; e_t = v.t; e_m = v.m;
      @(negedge clk);
      check($sformatf("v%0d_send", i), 32'(send_resp), 32'd1);
      check($sformatf("v%0d_resp", i), 32'(resp), 32'(v.rsp));
      check($sformatf("v%0d_clr_lo", i), 32'(clr_cmd_rdy), 32'd0);
      check_setpoints($sformatf("v%0d", i));
      tick();
   endtask

   // full SET_CAL sequence; cal_done driven dly cycles after strt_cal (dly >= 2)
   task automatic run_cal(input string nm, input int dly);
      int found;
      cmd_rdy = 1'b1;
      cmd     = 8'h06;
      data    = 16'hABCD;
      @(negedge clk);
      check({nm, "_clr"}, 32'(clr_cmd_rdy), 32'd1);
      tick();
      cmd_rdy = 1'b0;
      found = 0;
      for (int j = 1; j <= 200; j++) begin
         cal_done = (j == 3);
         @(negedge clk);
         if (j == 1) begin
            check({nm, "_ical_on"}, 32'(inertial_cal), 32'd1);
            check({nm, "_mon"}, 32'(motors_off), 32'd0);
            check({nm, "_ll_clr"}, 32'(link_lost), 32'd0);
         end
         if (strt_cal) begin
            found = j;
            break;
         end
         tick();
      end
      cal_done = 1'b0;
      check({nm, "_strt_lat"}, 32'(found), 32'd64);
      tick();
      @(negedge clk);
      check({nm, "_strt_pulse"}, 32'(strt_cal), 32'd0);
      check({nm, "_ical_hold"}, 32'(inertial_cal), 32'd1);
      for (int k = 2; k < dly; k++) tick();
      tick();
      cal_done = 1'b1;
      @(negedge clk);
      check({nm, "_noresp"}, 32'(send_resp), 32'd0);
      tick();
      cal_done = 1'b0;
      e_m = 1'b0;
      @(negedge clk);
      check({nm, "_send"}, 32'(send_resp), 32'd1);
      check({nm, "_resp"}, 32'(resp), 32'hA5);
      check({nm, "_ical_off"}, 32'(inertial_cal), 32'd0);
      check_setpoints(nm);
      tick();
   endtask

   initial begin
      int fire_k;
      int seen;
      vecs[0]  = '{8'h02, 16'h0100, 8'hA5, 16'h0100, 16'h0000, 16'h0000, 9'h000, 1'b1};
      vecs[1]  = '{8'h04, 16'h1234, 8'hA5, 16'h0100, 16'h0000, 16'h1234, 9'h000, 1'b1};
      vecs[2]  = '{8'h05, 16'hFEFF, 8'hA5, 16'h0100, 16'h0000, 16'h1234, 9'h0FF, 1'b1};
      vecs[3]  = '{8'h3C, 16'h5555, 8'hEE, 16'h0100, 16'h0000, 16'h1234, 9'h0FF, 1'b1};
      vecs[4]  = '{8'h03, 16'hFF80, 8'hA5, 16'h0100, 16'hFF80, 16'h1234, 9'h0FF, 1'b1};
      vecs[5]  = '{8'h02, 16'h8000, 8'hA5, 16'h8000, 16'hFF80, 16'h1234, 9'h0FF, 1'b0};
      vecs[6]  = '{8'h00, 16'hFFFF, 8'hEE, 16'h8000, 16'hFF80, 16'h1234, 9'h0FF, 1'b0};
      vecs[7]  = '{8'h07, 16'h1111, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b0};
      vecs[8]  = '{8'h05, 16'h00AA, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h0AA, 1'b0};
      vecs[9]  = '{8'h02, 16'h0033, 8'hA5, 16'h0033, 16'h0000, 16'h0000, 9'h000, 1'b0};
      vecs[10] = '{8'h05, 16'h0077, 8'hA5, 16'h0033, 16'h0000, 16'h0000, 9'h077, 1'b0};
      vecs[11] = '{8'h04, 16'h0042, 8'hA5, 16'h0033, 16'h0000, 16'h0042, 9'h077, 1'b0};
      vecs[12] = '{8'h05, 16'h01AB, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h1AB, 1'b0};
      vecs[13] = '{8'h08, 16'h0000, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1};

      rst = 1'b1; cmd_rdy = 1'b0; cmd = 8'h00; data = 16'h0000; cal_done = 1'b0;
      e_p = 16'h0000; e_r = 16'h0000; e_y = 16'h0000; e_t = 9'h000; e_m = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_setpoints("rst");
      check("rst_ical", 32'(inertial_cal), 32'd0);
      check("rst_ll", 32'(link_lost), 32'd0);
      check("rst_resp", 32'(resp), 32'h00);
      check("rst_pulses", 32'({send_resp, strt_cal, clr_cmd_rdy}), 32'd0);
      tick();

      for (int i = 0; i <= 4; i++) do_vec(i);
      run_cal("cal1", 10);
      for (int i = 5; i <= 8; i++) do_vec(i);

      // SET_THRST followed by SET_ROLL already pending during RESP
      cmd_rdy = 1'b1; cmd = 8'h05; data = 16'hFEFF;
      @(negedge clk);
      check("pend_clr1", 32'(clr_cmd_rdy), 32'd1);
      tick();
      cmd = 8'h03; data = 16'hFF80;
      @(negedge clk);
      check("pend_send1", 32'(send_resp), 32'd1);
      check("pend_resp1", 32'(resp), 32'hA5);
      check("pend_noclr", 32'(clr_cmd_rdy), 32'd0);
      check("pend_thr", 32'(thrst), 32'h0FF);
      tick();
      @(negedge clk);
      check("pend_clr2", 32'(clr_cmd_rdy), 32'd1);
      check("pend_nosend", 32'(send_resp), 32'd0);
      tick();
      cmd_rdy = 1'b0;
      @(negedge clk);
      check("pend_send2", 32'(send_resp), 32'd1);
      check("pend_clr2_lo", 32'(clr_cmd_rdy), 32'd0);
      check("pend_roll", 32'(d_roll), 32'hFF80);
      e_t = 9'h0FF; e_r = 16'hFF80;
      tick();

      // watchdog expiry with motors enabled and no commands
      fire_k = 0;
      seen = 0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (send_resp) seen++;
         if (link_lost) begin
            fire_k = k;
            break;
         end
         tick();
      end
      e_p = 16'h0000; e_r = 16'h0000; e_y = 16'h0000; e_t = 9'h000;
      check("wd_fire_cycle", 32'(fire_k), 32'd256);
      check("wd_noresp", 32'(seen), 32'd0);
      check_setpoints("wd");
      tick();

      do_vec(9);
      run_cal("cal2", 2);
      do_vec(10);
      // command lands on the would-be expiry cycle
      repeat (254) tick();
      do_vec(11);
      @(negedge clk);
      check("wd_coinc_ll", 32'(link_lost), 32'd0);
      tick();

      // rst during CAL
      cmd_rdy = 1'b1; cmd = 8'h06; data = 16'h0000;
      tick();
      cmd_rdy = 1'b0;
      fire_k = 0;
      for (int j = 1; j <= 200; j++) begin
         @(negedge clk);
         if (strt_cal) begin
            fire_k = j;
            break;
         end
         tick();
      end
      check("rc_strt_lat", 32'(fire_k), 32'd64);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      e_p = 16'h0000; e_r = 16'h0000; e_y = 16'h0000; e_t = 9'h000; e_m = 1'b1;
      @(negedge clk);
      check_setpoints("rc");
      check("rc_ical", 32'(inertial_cal), 32'd0);
      check("rc_resp", 32'(resp), 32'h00);
      tick();
      cal_done = 1'b1;
      seen = 0;
      @(negedge clk);
      if (send_resp) seen++;
      tick();
      cal_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (send_resp) seen++;
         tick();
      end
      check("rc_noresp", 32'(seen), 32'd0);

      run_cal("cal3", 2);
      do_vec(12);
      do_vec(13);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
